// File: rtl/raven_spi_pkg.sv
// raven_spi_pkg: shared state encoding and command constants for the Raven SPI initiator
package raven_spi_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;
  localparam logic [7:0] CMD_WRITE = 8'h80;
  localparam logic [7:0] CMD_READ = 8'h40;
  localparam logic [7:0] CMD_RW = 8'hC0;
  localparam int MAX_NBYTES = 15;
endpackage

// File: rtl/raven_spi_tick.sv
// raven_spi_tick: half-period timer pulsing tick every CLK_DIV cycles after clear
module raven_spi_tick #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);
  localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLK_DIV - 1);
  always_ff @(posedge clk)
    cnt <= (reset || clear || tick) ? '0 : cnt + W'(1);
endmodule

// File: rtl/raven_spi_master.sv
// raven_spi_master: mode-0 SPI initiator shifting cmd, addr and 0-15 full-duplex data bytes
module raven_spi_master
  import raven_spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] cmd,
  input  logic [7:0] addr,
  input  logic [3:0] nbytes,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       busy,
  output logic       done,
  output logic       csb,
  output logic       sck,
  output logic       sdi,
  input  logic       sdo
);
  state_t state, state_d;
  logic tick, accept, rise, fall, at_last, byte_end;
  logic [10:0] bit_idx, last_bit;
  logic [7:0] tx_sh, rx_sh, addr_q, next_byte;
  logic [3:0] nb;
  assign accept = state == IDLE && start;
  assign rise = state == SHIFT && tick && !sck;
  assign fall = state == SHIFT && tick && sck;
  assign last_bit = {4'd0, nb, 3'd0} + 11'd15;
  assign at_last = bit_idx == last_bit;
  assign byte_end = bit_idx[2:0] == 3'd7;
  assign next_byte = bit_idx[10:3] == 8'd0 ? addr_q : tx_data;
  raven_spi_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk(clk),
    .reset(reset),
    .clear(accept),
    .tick(tick)
  );
  always_comb begin
    state_d = state;
    state_d = accept ? SHIFT :
              (fall && at_last) ? HOLD :
              (state == HOLD && tick) ? GAP :
              (state == GAP && tick) ? IDLE : state;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      csb <= 1'b1;
      sck <= 1'b0;
      sdi <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      rx_data <= 8'h00;
      bit_idx <= '0;
      tx_sh <= '0;
      rx_sh <= '0;
      addr_q <= '0;
      nb <= '0;
    end else begin
      state <= state_d;
      done <= 1'b0;
      tx_ready <= 1'b0;
      rx_valid <= 1'b0;
      if (accept) begin
        csb <= 1'b0;
        busy <= 1'b1;
        tx_sh <= cmd;
        sdi <= cmd[7];
        addr_q <= addr;
        nb <= nbytes;
        bit_idx <= '0;
      end
      if (rise) begin
        sck <= 1'b1;
        rx_sh <= {rx_sh[6:0], sdo};
        if (byte_end && |bit_idx[10:4]) begin
          rx_data <= {rx_sh[6:0], sdo};
          rx_valid <= 1'b1;
        end
      end
      if (fall) begin
        sck <= 1'b0;
        bit_idx <= bit_idx + 11'd1;
        if (!at_last && byte_end) begin
          tx_sh <= next_byte;
          sdi <= next_byte[7];
          tx_ready <= |bit_idx[10:3];
        end else if (!at_last) begin
          tx_sh <= {tx_sh[6:0], 1'b0};
          sdi <= tx_sh[6];
        end
      end
      if (state == HOLD && tick) begin
        csb <= 1'b1;
        done <= 1'b1;
        sdi <= 1'b0;
      end
      if (state == GAP && tick)
        busy <= 1'b0;
    end
  end
endmodule

// File: tb/tb_raven_spi_master.sv
// tb_raven_spi_master: directed vector bench with a responder model for raven_spi_master
module tb_raven_spi_master;
  logic clk = 0, reset = 1, start = 0, sel = 0, clr = 0, sdo_m = 0;
  logic [7:0] cmd = 0, addr = 0, tx_data = 0, tx_base = 0, rb0 = 0, rb1 = 0;
  logic [3:0] nbytes = 0;
  logic start0, start1;
  logic txr0, rxv0, busy0, done0, csb0, sck0, sdi0;
  logic txr1, rxv1, busy1, done1, csb1, sck1, sdi1;
  logic [7:0] rxd0, rxd1;
  logic m_txr, m_rxv, m_busy, m_done, m_csb, m_sck, m_sdi;
  logic [7:0] m_rxd;
  int cyc = 0, checks = 0, failures = 0, k = 0;
  typedef struct {
    logic sel;
    int d;
    logic [7:0] cmd, addr;
    logic [3:0] nb;
    logic [7:0] tx_base, rb0, rb1;
    int csb_low, done_at, busy_at;
  } vec_t;
  vec_t vecs[4];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  assign start0 = start && !sel;
  assign start1 = start && sel;
  assign m_txr = sel ? txr1 : txr0;
  assign m_rxv = sel ? rxv1 : rxv0;
  assign m_busy = sel ? busy1 : busy0;
  assign m_done = sel ? done1 : done0;
  assign m_csb = sel ? csb1 : csb0;
  assign m_sck = sel ? sck1 : sck0;
  assign m_sdi = sel ? sdi1 : sdi0;
  assign m_rxd = sel ? rxd1 : rxd0;
  raven_spi_master #(.CLK_DIV(2)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .cmd(cmd), .addr(addr), .nbytes(nbytes),
    .tx_data(tx_data), .tx_ready(txr0), .rx_data(rxd0), .rx_valid(rxv0), .busy(busy0),
    .done(done0), .csb(csb0), .sck(sck0), .sdi(sdi0), .sdo(sdo_m)
  );
  raven_spi_master #(.CLK_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .cmd(cmd), .addr(addr), .nbytes(nbytes),
    .tx_data(tx_data), .tx_ready(txr1), .rx_data(rxd1), .rx_valid(rxv1), .busy(busy1),
    .done(done1), .csb(csb1), .sck(sck1), .sdi(sdi1), .sdo(sdo_m)
  );
  int rbit = 0, nsck = 0, csb_low = 0;
  logic [7:0] cap = 0, b;
  logic csb_p = 1, sck_p = 0, busy_p = 0;
  logic [7:0] cap_q[$], rx_q[$];
  int txr_q[$], done_q[$], fall_q[$], rise_q[$], bfall_q[$];
  function automatic logic [7:0] rsp_byte(input int n);
    return n < 2 ? 8'hFF : ((n % 2 == 0) ? rb0 : rb1);
  endfunction
  always @(negedge clk) begin
    if (clr) begin
      rbit = 0; nsck = 0; csb_low = 0;
      cap_q.delete(); rx_q.delete(); txr_q.delete(); done_q.delete();
      fall_q.delete(); rise_q.delete(); bfall_q.delete();
    end else begin
      if (csb_p && !m_csb) begin
        rbit = 0; b = rsp_byte(0); sdo_m = b[7]; fall_q.push_back(cyc);
      end
      if (!csb_p && m_csb) rise_q.push_back(cyc);
      if (!m_csb) csb_low++;
      if (!m_csb && m_sck && !sck_p) begin
        cap = {cap[6:0], m_sdi}; rbit++; nsck++;
        if (rbit % 8 == 0) cap_q.push_back(cap);
      end
      if (!m_csb && !m_sck && sck_p) begin
        b = rsp_byte(rbit / 8); sdo_m = b[7 - rbit % 8];
      end
      if (m_txr) txr_q.push_back(cyc);
      if (m_rxv) rx_q.push_back(m_rxd);
      if (m_done) done_q.push_back(cyc);
      if (busy_p && !m_busy) bfall_q.push_back(cyc);
    end
    csb_p = m_csb; sck_p = m_sck; busy_p = m_busy;
    tx_data = tx_base + 8'(txr_q.size());
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic clear_mon();
    clr = 1; @(negedge clk); @(posedge clk); clr = 0;
  endtask
  task automatic wait_idle(input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end while (m_busy && n < 3000);
    chk({nm, "_idle_timeout"}, m_busy, 0);
  endtask
  task automatic run(input vec_t v, input string nm);
    int n;
    sel = v.sel; cmd = v.cmd; addr = v.addr; nbytes = v.nb;
    tx_base = v.tx_base; rb0 = v.rb0; rb1 = v.rb1;
    clear_mon();
    @(negedge clk); start = 1; k = cyc + 1;
    @(negedge clk); start = 0;
    wait_idle(nm);
    n = int'(v.nb);
    chk({nm, "_ncap"}, cap_q.size(), 2 + n);
    if (cap_q.size() == 2 + n) begin
      chk({nm, "_cap_cmd"}, cap_q[0], v.cmd);
      chk({nm, "_cap_addr"}, cap_q[1], v.addr);
      for (int i = 0; i < n; i++) chk({nm, "_cap_data"}, cap_q[2 + i], v.tx_base + 8'(i));
    end
    chk({nm, "_nrx"}, rx_q.size(), n);
    if (rx_q.size() == n)
      for (int i = 0; i < n; i++) chk({nm, "_rx_data"}, rx_q[i], (i % 2 == 0) ? v.rb0 : v.rb1);
    chk({nm, "_ntx_ready"}, txr_q.size(), n);
    if (txr_q.size() == n)
      for (int i = 1; i < n; i++) chk({nm, "_tx_ready_gap"}, txr_q[i] - txr_q[i - 1], 16 * v.d);
    chk({nm, "_ndone"}, done_q.size(), 1);
    chk({nm, "_nsck"}, nsck, 16 + 8 * n);
    chk({nm, "_csb_low"}, csb_low, v.csb_low);
    if (done_q.size() == 1) chk({nm, "_done_at"}, done_q[0] - k, v.done_at);
    if (bfall_q.size() == 1) chk({nm, "_busy_at"}, bfall_q[0] - k, v.busy_at);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    vecs[0] = '{1'b0, 2, 8'h80, 8'h02, 4'd1, 8'hA5, 8'h00, 8'h00, 98, 98, 100};
    vecs[1] = '{1'b0, 2, 8'h40, 8'h00, 4'd2, 8'h11, 8'h3C, 8'hC3, 130, 130, 132};
    vecs[2] = '{1'b0, 2, 8'hC0, 8'h10, 4'd0, 8'h00, 8'h00, 8'h00, 66, 66, 68};
    vecs[3] = '{1'b1, 1, 8'h80, 8'h20, 4'd15, 8'h00, 8'h5A, 8'h96, 273, 273, 274};
    repeat (3) @(negedge clk);
    chk("rst_csb", csb0, 1);
    chk("rst_sck", sck0, 0);
    chk("rst_sdi", sdi0, 0);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_tx_ready", txr0, 0);
    chk("rst_rx_valid", rxv0, 0);
    chk("rst_rx_data", rxd0, 8'h00);
    chk("rst_csb1", csb1, 1);
    reset = 0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) run(vecs[i], $sformatf("vec%0d", i));
    // ignored mid-transaction start, then start held high across the busy fall
    sel = 0; cmd = 8'hC0; addr = 8'h10; nbytes = 0; tx_base = 0; rb0 = 0; rb1 = 0;
    clear_mon();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (20) @(negedge clk);
    cmd = 8'h12; addr = 8'h34; nbytes = 4'd5; start = 1;
    @(negedge clk); start = 0;
    repeat (20) @(negedge clk);
    cmd = 8'h40; addr = 8'h33; nbytes = 0; start = 1;
    for (int n = 0; n < 300 && fall_q.size() < 2; n++) @(negedge clk);
    start = 0;
    chk("hold_nfall", fall_q.size(), 2);
    wait_idle("hold");
    chk("hold_ndone", done_q.size(), 2);
    chk("hold_ncap", cap_q.size(), 4);
    if (cap_q.size() == 4) begin
      chk("hold_cap0", cap_q[0], 8'hC0);
      chk("hold_cap1", cap_q[1], 8'h10);
      chk("hold_cap2", cap_q[2], 8'h40);
      chk("hold_cap3", cap_q[3], 8'h33);
    end
    if (fall_q.size() == 2 && bfall_q.size() >= 1 && rise_q.size() >= 1) begin
      chk("hold_restart_edge", fall_q[1] - bfall_q[0], 1);
      chk("hold_csb_high", fall_q[1] - rise_q[0], 3);
    end
    // reset while shifting bit 12
    cmd = 8'h80; addr = 8'h02; nbytes = 4'd1; tx_base = 8'hA5;
    clear_mon();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (49) @(negedge clk);
    chk("pre_rst_busy", busy0, 1);
    reset = 1;
    @(negedge clk);
    chk("abort_csb", csb0, 1);
    chk("abort_sck", sck0, 0);
    chk("abort_sdi", sdi0, 0);
    chk("abort_busy", busy0, 0);
    reset = 0;
    repeat (10) @(negedge clk);
    chk("abort_ndone", done_q.size(), 0);
    chk("abort_busy_after", busy0, 0);
    run(vecs[0], "post_rst");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
